rd53_hit_tot_capture: RTL and testbench

- Digital receiver for the single-ended asynchronous front-end discriminator output HIT.
- Synchronises HIT to the 40 MHz bunch-crossing clock and measures time-over-threshold (ToT) in clock cycles.
- Tags each hit with the BCID of its leading edge.
- Queues {BCID, ToT} words in a small FIFO drained by a valid/ready handshake toward pixel-region logic.
- Masks powered-down or disabled pixels, whose discriminator output is stuck at 1.

---
 rtl/rd53_hit_tot_capture.sv | 195 +++++++++++++++++++
 tb/tb_rd53_hit_tot_capture.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd53_hit_tot_capture.sv
// rd53_hit_tot_capture
//
// Receives the asynchronous discriminator output of one pixel, synchronises it to the
// bunch-crossing clock, measures time-over-threshold (ToT) in clock cycles and queues
// {leading-edge BCID, ToT} words in a small FIFO drained with a valid/ready handshake.
// Disabled or powered-down pixels (discriminator stuck at 1) are masked.
//
// Ports:
//   clk_i        bunch-crossing clock (40 MHz)
//   rst_ni       asynchronous active-low reset
//   hit_i        asynchronous discriminator output
//   mask_i       pixel disabled / AFE powered down (synchronous level)
//   bcid_i       free-running bunch-crossing counter
//   tot_valid_o  FIFO head valid
//   tot_ready_i  consumer accepts head
//   tot_bcid_o   leading-edge BCID of head word
//   tot_data_o   ToT of head word (all ones means ToT >= maximum)
//   busy_o       measurement in progress
//   drop_cnt_o   saturating count of hits lost to a full FIFO

module rd53_hit_tot_capture #(
    parameter int unsigned TOT_W       = 4,
    parameter int unsigned BCID_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,  // >= 2
    parameter int unsigned FIFO_DEPTH  = 4   // power of 2, >= 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              hit_i,
    input  logic              mask_i,
    input  logic [BCID_W-1:0] bcid_i,
    output logic              tot_valid_o,
    input  logic              tot_ready_i,
    output logic [BCID_W-1:0] tot_bcid_o,
    output logic [TOT_W-1:0]  tot_data_o,
    output logic              busy_o,
    output logic [7:0]        drop_cnt_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned WW = BCID_W + TOT_W;
    localparam logic [TOT_W-1:0] TotMax = {TOT_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StWaitLow
    } state_e;

    // ------------------------------------------------------------------
    // Synchroniser and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   hit_prev_q;
    logic                   hit_s;
    logic                   primed;
    logic                   rise;
    logic                   fall;

    assign hit_s  = sync_q[SYNC_STAGES-1];
    // hit_s and hit_prev only reflect real HIT samples once the reset zeros have been
    // flushed. Without this, HIT held high across reset would look like a fresh rise.
    assign primed = prime_q[SYNC_STAGES];
    assign rise   = hit_s & ~hit_prev_q & primed;
    assign fall   = ~hit_s & hit_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q     <= '0;
            prime_q    <= '0;
            hit_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], hit_i};
            prime_q    <= {prime_q[SYNC_STAGES-1:0], 1'b1};
            hit_prev_q <= hit_s;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_e             state_q;
    logic [TOT_W-1:0]   cnt_q;
    logic [BCID_W-1:0]  bcid_l_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bcid_l_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise && !mask_i) begin
                        state_q  <= StCount;
                        cnt_q    <= TOT_W'(1);
                        bcid_l_q <= bcid_i;
                    end
                end
                StCount: begin
                    // Mask wins over a coincident fall: the measurement is discarded.
                    if (mask_i) begin
                        state_q <= hit_s ? StWaitLow : StIdle;
                    end else if (fall) begin
                        state_q <= StIdle;
                    end else if (cnt_q != TotMax) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitLow: begin
                    if (!hit_s && !mask_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o = (state_q == StCount);

    logic          push_req;
    logic [WW-1:0] push_word;

    assign push_req  = (state_q == StCount) & ~mask_i & fall;
    assign push_word = {bcid_l_q, cnt_q};

    // ------------------------------------------------------------------
    // Output FIFO with registered head
    // ------------------------------------------------------------------
    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          valid_q, valid_d;
    logic [WW-1:0] head_q, head_d;
    logic [7:0]    drop_q, drop_d;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;

    always_comb begin
        pop      = valid_q & tot_ready_i;
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        // A full FIFO still takes a word when its head leaves in the same cycle.
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        valid_d  = (wr_ptr_d != rd_ptr_d);
        head_d   = head_q;
        if (valid_d) begin
            // The word being written this cycle may itself become the new head.
            if (push_ok && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
                head_d = push_word;
            end else begin
                head_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
        drop_d = drop_q;
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_word;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
            drop_q   <= drop_d;
        end
    end

    assign tot_valid_o = valid_q;
    assign tot_bcid_o  = head_q[WW-1:TOT_W];
    assign tot_data_o  = head_q[TOT_W-1:0];
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_rd53_hit_tot_capture.sv
// Directed, table-driven bench for rd53_hit_tot_capture (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.

`timescale 1ns/1ps

module tb_rd53_hit_tot_capture;

    logic       clk;
    logic       rst_n;
    logic       hit;
    logic       mask;
    logic [7:0] bcid;
    logic       ready;
    logic       valid;
    logic [7:0] tbcid;
    logic [3:0] tdata;
    logic       busy;
    logic [7:0] drop;

    int tests;
    int fails;

    rd53_hit_tot_capture #(
        .TOT_W      (4),
        .BCID_W     (8),
        .SYNC_STAGES(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .hit_i      (hit),
        .mask_i     (mask),
        .bcid_i     (bcid),
        .tot_valid_o(valid),
        .tot_ready_i(ready),
        .tot_bcid_o (tbcid),
        .tot_data_o (tdata),
        .busy_o     (busy),
        .drop_cnt_o (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hi_cycles;
        int exp_tot;
    } vec_t;

    vec_t vecs[7];

    task automatic step();
        @(posedge clk);
        #1;
        bcid = bcid + 8'd1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One isolated pulse of n cycles; the word must appear 3 edges after HIT drops.
    task automatic run_pulse(input int n, input int exp_tot);
        logic [7:0] b;
        logic [7:0] eb;
        int         busy_n;
        b      = bcid;
        eb     = b + 8'd2;
        busy_n = 0;
        hit    = 1'b1;
        for (int i = 0; i < n; i++) begin
            step();
            busy_n += int'(busy);
        end
        hit = 1'b0;
        step();
        busy_n += int'(busy);
        step();
        busy_n += int'(busy);
        chk($sformatf("p%0d_valid_early", n), 32'(valid), 32'd0);
        step();
        busy_n += int'(busy);
        chk($sformatf("p%0d_valid", n), 32'(valid), 32'd1);
        chk($sformatf("p%0d_tot", n), 32'(tdata), 32'(exp_tot));
        chk($sformatf("p%0d_bcid", n), 32'(tbcid), 32'(eb));
        chk($sformatf("p%0d_drop", n), 32'(drop), 32'd0);
        ready = 1'b1;
        step();
        busy_n += int'(busy);
        ready = 1'b0;
        chk($sformatf("p%0d_single_word", n), 32'(valid), 32'd0);
        chk($sformatf("p%0d_busy_cycles", n), 32'(busy_n), 32'(n));
        step();
        step();
    endtask

    // Head must equal the expected 2-cycle word and hold through a stall, then is popped.
    task automatic drain_check(input logic [7:0] eb, input string tag);
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        chk({tag, "_bcid"}, 32'(tbcid), 32'(eb));
        chk({tag, "_tot"}, 32'(tdata), 32'd2);
        step();
        chk({tag, "_stall_bcid"}, 32'(tbcid), 32'(eb));
        chk({tag, "_stall_tot"}, 32'(tdata), 32'd2);
        ready = 1'b1;
        step();
        ready = 1'b0;
    endtask

    initial begin
        logic [7:0] bk[6];
        logic [7:0] bnew;
        logic [7:0] b;
        int         busy_n;
        int         vseen;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        hit   = 1'b0;
        mask  = 1'b0;
        bcid  = 8'd0;
        ready = 1'b0;

        vecs[0] = '{hi_cycles: 5,  exp_tot: 5};
        vecs[1] = '{hi_cycles: 1,  exp_tot: 1};
        vecs[2] = '{hi_cycles: 2,  exp_tot: 2};
        vecs[3] = '{hi_cycles: 14, exp_tot: 14};
        vecs[4] = '{hi_cycles: 15, exp_tot: 15};
        vecs[5] = '{hi_cycles: 16, exp_tot: 15};
        vecs[6] = '{hi_cycles: 40, exp_tot: 15};

        // Reset state
        #3;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_bcid", 32'(tbcid), 32'd0);
        chk("rst_tot", 32'(tdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_drop", 32'(drop), 32'd0);
        #20;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();

        // Basic ToT and saturation; first pulse starts at BCID 0x10
        bcid = 8'h10;
        for (int v = 0; v < 7; v++) begin
            run_pulse(vecs[v].hi_cycles, vecs[v].exp_tot);
        end

        // Stuck-high pixel under mask, then mask released with HIT still high
        busy_n = 0;
        vseen  = 0;
        mask   = 1'b1;
        hit    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        mask = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        chk("stuck_busy", 32'(busy_n), 32'd0);
        chk("stuck_no_word", 32'(vseen), 32'd0);
        run_pulse(3, 3);

        // Mask mid-COUNT: WAIT_LOW must hold while masked and ignore a rise seen as mask drops
        hit = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("midmask_busy_before", 32'(busy), 32'd1);
        mask = 1'b1;
        step();
        chk("midmask_busy_after", 32'(busy), 32'd0);
        hit = 1'b0;
        for (int i = 0; i < 4; i++) step();
        busy_n = 0;
        vseen  = 0;
        hit    = 1'b1;
        step();
        step();
        mask = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        chk("waitlow_busy", 32'(busy_n), 32'd0);
        chk("waitlow_no_word", 32'(vseen), 32'd0);

        // Mask coinciding with the fall edge discards the word
        hit = 1'b1;
        for (int i = 0; i < 4; i++) step();
        hit = 1'b0;
        step();
        step();
        mask = 1'b1;
        step();
        mask = 1'b0;
        chk("maskfall_valid", 32'(valid), 32'd0);
        for (int i = 0; i < 3; i++) step();
        chk("maskfall_valid_late", 32'(valid), 32'd0);
        chk("maskfall_busy", 32'(busy), 32'd0);
        run_pulse(2, 2);

        // Minimum spacing: 1 high, 1 low, 1 high
        b    = bcid;
        hit  = 1'b1;
        step();
        hit  = 1'b0;
        step();
        hit  = 1'b1;
        step();
        hit  = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("min_w0_valid", 32'(valid), 32'd1);
        chk("min_w0_bcid", 32'(tbcid), 32'(8'(b + 8'd2)));
        chk("min_w0_tot", 32'(tdata), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("min_w1_valid", 32'(valid), 32'd1);
        chk("min_w1_bcid", 32'(tbcid), 32'(8'(b + 8'd4)));
        chk("min_w1_tot", 32'(tdata), 32'd1);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("min_empty", 32'(valid), 32'd0);
        step();
        step();

        // Backpressure: six 2-cycle hits into a 4-deep FIFO
        for (int k = 0; k < 6; k++) begin
            bk[k] = bcid + 8'd2;
            hit   = 1'b1;
            step();
            step();
            hit   = 1'b0;
            step();
            step();
        end
        for (int i = 0; i < 3; i++) step();
        chk("ovf_drop", 32'(drop), 32'd2);
        chk("ovf_head_bcid", 32'(tbcid), 32'(bk[0]));
        // Push coincident with a pop while full
        bnew = bcid + 8'd2;
        hit  = 1'b1;
        step();
        step();
        hit  = 1'b0;
        step();
        step();
        chk("coinc_before_valid", 32'(valid), 32'd1);
        chk("coinc_before_bcid", 32'(tbcid), 32'(bk[0]));
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("coinc_drop", 32'(drop), 32'd2);
        drain_check(bk[1], "drain1");
        drain_check(bk[2], "drain2");
        drain_check(bk[3], "drain3");
        drain_check(bnew, "drain4");
        chk("drain_empty", 32'(valid), 32'd0);

        // Drop counter saturates at 255
        b = bcid + 8'd2;
        for (int k = 0; k < 260; k++) begin
            hit = 1'b1;
            step();
            step();
            hit = 1'b0;
            step();
            step();
        end
        for (int i = 0; i < 4; i++) step();
        chk("drop_sat", 32'(drop), 32'd255);
        chk("drop_sat_head", 32'(tbcid), 32'(b));
        ready = 1'b1;
        step();
        step();
        ready = 1'b0;
        chk("two_left_valid", 32'(valid), 32'd1);

        // Async reset mid-COUNT with two words queued
        hit = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("prerst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_drop", 32'(drop), 32'd0);
        #2;
        rst_n = 1'b1;
        busy_n = 0;
        vseen  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            busy_n += int'(busy);
            vseen  += int'(valid);
        end
        chk("postrst_busy", 32'(busy_n), 32'd0);
        chk("postrst_no_word", 32'(vseen), 32'd0);
        run_pulse(3, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
